mfreg_seq_ctrl: RTL and testbench
=================================

Name: mfreg_seq_ctrl

Overview:
- Command sequencer for the 4-bit multifunction shift register (`mfreg`: `clk`, `I`, `rst`, `ld`, `shr`, `shl`, `shin`, `Q`).
- Accepts one command per start pulse (load, clear, serial shift right/left, rotate right/left with a repeat count) and drives the register's control pins one operation per clock.
- Reports progress with a busy/done/err handshake.
- Sits between a host (bench, FSM or switch logic) and one `mfreg` instance; `q` is fed back from the register for rotates.

Parameters:
- W, 4, register width; must match the `mfreg` width.
- CW, 3, width of the repeat-count field.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  3  command: 000 LOAD, 001 CLEAR, 010 SHR_SER, 011 SHL_SER, 100 ROTR, 101 ROTL, 110/111 reserved.
- cnt  input  CW  number of shift/rotate steps.
- pat  input  W  serial pattern for SHR_SER/SHL_SER, consumed pat[0] first.
- din  input  W  load value for LOAD.
- q  input  W  live register output Q.
- busy  output  1  high while a command executes.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; command rejected.
- reg_i  output  W  to mfreg I.
- reg_rst  output  1  to mfreg rst; active-high clear.
- reg_ld  output  1  to mfreg ld.
- reg_shr  output  1  to mfreg shr.
- reg_shl  output  1  to mfreg shl.
- reg_shin  output  1  to mfreg shin.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-low. `rst`=0 at a rising edge forces state IDLE and clears all internal registers on that edge.
- Reset values: busy=0, done=0, err=0, reg_i=0, and reg_rst, reg_ld, reg_shr, reg_shl, reg_shin all 0.
- Reset mid-command aborts immediately. No done pulse is produced; the register keeps whatever value it had.
- Register convention assumed by this block: shr gives Q <= {shin, Q[W-1:1]}; shl gives Q <= {Q[W-2:0], shin}.
- FSM states: IDLE, EXEC, FIN.
- IDLE: start=1 latches op, cnt, pat and din, clears the step counter k, and moves to EXEC. start is ignored in EXEC and FIN (no queuing).
- Error check at acceptance: reserved op, or cnt=0 on a shift/rotate op, goes directly to FIN with err=1. No register control is asserted for a rejected command.
- EXEC: busy=1. Exactly one register control is asserted per cycle; the mfreg samples it on the following edge.
  - LOAD: reg_ld=1, reg_i=latched din; one cycle; cnt ignored.
  - CLEAR: reg_rst=1; one cycle; cnt ignored.
  - SHR_SER / SHL_SER: reg_shr or reg_shl=1 for cnt cycles. reg_shin=pat[k] for k<W, else 0.
  - ROTR: reg_shr=1, reg_shin=q[0]. ROTL: reg_shl=1, reg_shin=q[W-1]. Both use live q and run for cnt cycles.
  - k increments each EXEC cycle. Leave EXEC after cycle k=cnt-1 (or after one cycle for LOAD/CLEAR).
- FIN: done=1 for exactly one cycle; err is valid; busy=0; no controls asserted; next state IDLE.
- Latency: start sampled at edge 0. Control cycles occupy cycles 1..n, where n=cnt (1 for LOAD/CLEAR). done is high in cycle n+1. The earliest next start is sampled at edge n+2.
- At most one of reg_rst/reg_ld/reg_shr/reg_shl is high in any cycle. reg_i holds the latched din while idle after a LOAD.

Test Plan:
- Reset: hold rst=0 for 2 edges with start=1 and op=LOAD -> all outputs 0, busy never rises. Release rst=1 -> IDLE.
- LOAD then shift right: LOAD din=1010 -> reg_ld high for exactly 1 cycle, Q=1010, done in cycle 2. Then SHR_SER cnt=4 pat=0111 (shin order 1,1,1,0) -> Q sequence 1101, 1110, 1111, 0111; busy for 4 cycles; done=1, err=0.
- Shift left from Q=0111: SHL_SER cnt=4 pat=0111 -> Q 1111, 1111, 1111, 1110.
- Rotate from Q=1010: ROTR cnt=1 -> 0101. Then ROTL cnt=3 -> 1010, 0101, 1010. Over-length serial shift: SHR_SER cnt=6 pat=1111 from 0000 -> final Q=0011 (last two shin=0).
- Errors: op=111 or SHR_SER with cnt=0 -> done=1, err=1 the cycle after start; no control asserted; Q unchanged. CLEAR -> Q=0000, err=0.
- Start during busy and reset mid-op: start pulses in EXEC/FIN are ignored (command count unchanged). rst=0 in the 2nd cycle of SHR_SER cnt=4 -> controls drop next cycle, no done, Q reflects exactly 2 shifts.

Source files
------------

// File: rtl/mfreg_seq_ctrl.sv
// Command sequencer for the 4-bit multifunction shift register (mfreg).
// Turns one host command per start pulse into per-cycle ld/rst/shr/shl/shin controls.
//
// state | meaning
// IDLE  | waiting for start; latches the command on acceptance
// EXEC  | one register control per cycle, k counts steps
// FIN   | one-cycle done pulse, err valid, no controls
module mfreg_seq_ctrl #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [CW-1:0] cnt,
    input  logic [W-1:0]  pat,
    input  logic [W-1:0]  din,
    input  logic [W-1:0]  q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  reg_i,
    output logic          reg_rst,
    output logic          reg_ld,
    output logic          reg_shr,
    output logic          reg_shl,
    output logic          reg_shin
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_ROTL  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] k;
    logic [W-1:0]  pat_r;
    logic [W-1:0]  din_r;
    logic          err_r;
    logic          reject;
    logic          last_step;
    logic          shin_ser;

    // Rejected commands skip EXEC entirely, so no control ever reaches the register.
    always_comb begin
        reject = 1'b0;
        if (op > OP_ROTL)
            reject = 1'b1;
        else if (op >= OP_SHR && cnt == '0)
            reject = 1'b1;
    end

    assign last_step = (op_r == OP_LOAD) || (op_r == OP_CLEAR) || (k == cnt_r - CW'(1));

    // Pattern bits beyond the register width shift in as zero.
    assign shin_ser = |(pat_r & (W'(1) << k));

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r  <= '0;
            cnt_r <= '0;
            k     <= '0;
            pat_r <= '0;
            din_r <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        cnt_r <= cnt;
                        pat_r <= pat;
                        k     <= '0;
                        err_r <= reject;
                        // reg_i keeps the last loaded value; other commands leave it alone.
                        if (op == OP_LOAD)
                            din_r <= din;
                    end
                end
                EXEC:    k <= k + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = reject ? FIN : EXEC;
            end
            EXEC: begin
                if (last_step)
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        reg_i    = din_r;
        reg_rst  = 1'b0;
        reg_ld   = 1'b0;
        reg_shr  = 1'b0;
        reg_shl  = 1'b0;
        reg_shin = 1'b0;
        case (state)
            EXEC: begin
                busy = 1'b1;
                case (op_r)
                    OP_LOAD:  reg_ld  = 1'b1;
                    OP_CLEAR: reg_rst = 1'b1;
                    OP_SHR: begin
                        reg_shr  = 1'b1;
                        reg_shin = shin_ser;
                    end
                    OP_SHL: begin
                        reg_shl  = 1'b1;
                        reg_shin = shin_ser;
                    end
                    OP_ROTR: begin
                        reg_shr  = 1'b1;
                        reg_shin = q[0];
                    end
                    OP_ROTL: begin
                        reg_shl  = 1'b1;
                        reg_shin = q[W-1];
                    end
                    default: ;
                endcase
            end
            FIN: begin
                done = 1'b1;
                err  = err_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mfreg_seq_ctrl.sv
// Self-checking bench for mfreg_seq_ctrl with a behavioural mfreg in the feedback loop.
// Expected register values and handshake timing come from a per-command reference model.
module tb_mfreg_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [2:0] cnt = 3'b000;
    logic [3:0] pat = 4'b0000;
    logic [3:0] din = 4'b0000;
    logic [3:0] q = 4'b0000;
    logic       busy, done, err;
    logic [3:0] reg_i;
    logic       reg_rst, reg_ld, reg_shr, reg_shl, reg_shin;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_done_exp = 0;
    logic [3:0] qm = 4'b0000;
    logic [3:0] li = 4'b0000;

    mfreg_seq_ctrl #(.W(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cnt(cnt), .pat(pat),
        .din(din), .q(q), .busy(busy), .done(done), .err(err), .reg_i(reg_i),
        .reg_rst(reg_rst), .reg_ld(reg_ld), .reg_shr(reg_shr), .reg_shl(reg_shl),
        .reg_shin(reg_shin)
    );

    always #5 clk = ~clk;

    // Behavioural mfreg: clear > load > shift right > shift left.
    always @(posedge clk) begin
        if (reg_rst)      q <= 4'b0000;
        else if (reg_ld)  q <= reg_i;
        else if (reg_shr) q <= {reg_shin, q[3:1]};
        else if (reg_shl) q <= {q[2:0], reg_shin};
    end

    always @(posedge clk) if (done) n_done <= n_done + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {1'b0, busy, done, err, reg_rst, reg_ld, reg_shr, reg_shl};
    endfunction

    function automatic logic [7:0] mk(input bit b, input bit d, input bit e,
                                      input bit r, input bit l, input bit sr, input bit sl);
        return {1'b0, b, d, e, r, l, sr, sl};
    endfunction

    // One step of the register as seen from the command: returns next Q.
    function automatic logic [3:0] step(input logic [2:0] o, input logic [3:0] qv,
                                        input logic [3:0] p, input logic [3:0] d, input int i);
        int s;
        s = (i < 4) ? ((p / (1 << i)) % 2) : 0;
        case (o)
            3'd0: return d;
            3'd1: return 4'd0;
            3'd2: return 4'((qv / 2) + 8 * s);
            3'd3: return 4'(((qv * 2) % 16) + s);
            3'd4: return 4'((qv / 2) + 8 * (qv % 2));
            default: return 4'(((qv * 2) % 16) + (qv / 8));
        endcase
    endfunction

    function automatic bit exp_shin(input logic [2:0] o, input logic [3:0] qv,
                                    input logic [3:0] p, input int i);
        if (o == 3'd2 || o == 3'd3) return (i < 4) ? bit'((p / (1 << i)) % 2) : 1'b0;
        if (o == 3'd4) return bit'(qv % 2);
        return bit'(qv / 8);
    endfunction

    task automatic run_cmd(input logic [2:0] o, input logic [2:0] c, input logic [3:0] p,
                           input logic [3:0] d, input bit hold);
        bit rej;
        int n;
        rej = (o > 3'd5) || (o >= 3'd2 && c == 3'd0);
        n = rej ? 0 : ((o < 3'd2) ? 1 : int'(c));
        @(negedge clk);
        start = 1'b1; op = o; cnt = c; pat = p; din = d;
        @(posedge clk); #1;
        if (hold) begin
            op = 3'd0; din = ~d;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            chk("exec_ctl", ctl(), mk(1, 0, 0, o == 3'd1, o == 3'd0,
                                      o == 3'd2 || o == 3'd4, o == 3'd3 || o == 3'd5));
            if (o >= 3'd2)
                chk("exec_shin", {7'd0, reg_shin}, {7'd0, exp_shin(o, qm, p, i)});
            if (o == 3'd0)
                chk("load_i", {4'd0, reg_i}, {4'd0, d});
            qm = step(o, qm, p, d, i);
            @(posedge clk); #1;
            chk("q_step", {4'd0, q}, {4'd0, qm});
        end
        if (o == 3'd0 && !rej) li = d;
        chk("fin_ctl", ctl(), mk(0, 1, rej, 0, 0, 0, 0));
        n_done_exp++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_ctl", ctl(), mk(0, 0, 0, 0, 0, 0, 0));
        chk("idle_i", {4'd0, reg_i}, {4'd0, li});
        chk("q_hold", {4'd0, q}, {4'd0, qm});
    endtask

    initial begin
        // Reset held with a pending LOAD request: nothing may move.
        rst = 1'b0; start = 1'b1; op = 3'd0; din = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_ctl", ctl(), 8'd0);
            chk("rst_i", {4'd0, reg_i}, 8'd0);
        end
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ctl", ctl(), 8'd0);

        run_cmd(3'd0, 3'd0, 4'b0000, 4'b1010, 0);
        run_cmd(3'd2, 3'd4, 4'b0111, 4'b0000, 0);
        run_cmd(3'd3, 3'd4, 4'b0111, 4'b0000, 0);
        chk("shl_final", {4'd0, q}, 8'h0E);
        run_cmd(3'd0, 3'd0, 4'b0000, 4'b1010, 0);
        run_cmd(3'd4, 3'd1, 4'b0000, 4'b0000, 0);
        chk("rotr_final", {4'd0, q}, 8'h05);
        run_cmd(3'd5, 3'd3, 4'b0000, 4'b0000, 0);
        chk("rotl_final", {4'd0, q}, 8'h0A);
        run_cmd(3'd1, 3'd5, 4'b0000, 4'b0000, 0);
        run_cmd(3'd2, 3'd6, 4'b1111, 4'b0000, 0);
        chk("overlen_final", {4'd0, q}, 8'h03);
        run_cmd(3'd7, 3'd3, 4'b0101, 4'b1100, 0);
        run_cmd(3'd2, 3'd0, 4'b1111, 4'b1100, 0);
        run_cmd(3'd1, 3'd0, 4'b0000, 4'b0000, 0);
        chk("clear_final", {4'd0, q}, 8'h00);

        // Start held through EXEC and FIN with a different command must be ignored.
        run_cmd(3'd0, 3'd0, 4'b0000, 4'b0110, 0);
        run_cmd(3'd2, 3'd4, 4'b0101, 4'b0011, 1);
        @(posedge clk); #1;
        chk("hold_idle", ctl(), 8'd0);
        chk("done_count", 8'(n_done), 8'(n_done_exp));

        // Reset during the second shift of a four-step SHR.
        run_cmd(3'd0, 3'd0, 4'b0000, 4'b1001, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; cnt = 3'd4; pat = 4'b0101;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort_c1", ctl(), mk(1, 0, 0, 0, 0, 1, 0));
        qm = step(3'd2, qm, 4'b0101, 4'd0, 0);
        @(posedge clk); #1;
        chk("abort_c2", ctl(), mk(1, 0, 0, 0, 0, 1, 0));
        qm = step(3'd2, qm, 4'b0101, 4'd0, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ctl", ctl(), 8'd0);
        chk("abort_q", {4'd0, q}, {4'd0, qm});
        rst = 1'b1;
        li = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_idle", ctl(), 8'd0);
        end
        chk("abort_q_hold", {4'd0, q}, {4'd0, qm});
        chk("abort_no_done", 8'(n_done), 8'(n_done_exp));

        for (int t = 0; t < 40; t++)
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)));
        chk("rand_done_count", 8'(n_done), 8'(n_done_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
